packet_link_arbiter: RTL

Packet-granular round-robin arbiter that shares one credit-based NoC output link among N_PORTS requesters using the tx/eop/credit handshake. Once granted, a requester holds the link until its EOP flit transfers (wormhole semantics). A watchdog flags a granted packet that makes no progress for TIMEOUT cycles, which exposes hung links such as those produced by fault-injection blocks. It sits between router input buffers and one output port.

---
 rtl/packet_link_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/packet_link_arbiter.sv
// Packet-granular round-robin arbiter sharing one credit-based output link among
// N_PORTS requesters, with wormhole grant hold and a no-progress watchdog.
module packet_link_arbiter #(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned FLIT_SIZE = 32,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_PORTS-1:0]           req_tx_i,
  input  logic [N_PORTS*FLIT_SIZE-1:0] req_data_i,
  input  logic [N_PORTS-1:0]           req_eop_i,
  output logic [N_PORTS-1:0]           req_cr_o,
  output logic                         tx_o,
  output logic [FLIT_SIZE-1:0]         data_o,
  output logic                         eop_o,
  input  logic                         cr_i,
  output logic [N_PORTS-1:0]           grant_o,
  output logic                         busy_o,
  output logic                         stall_o
);

  localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [N_PORTS-1:0] arb_req;
  logic [IDX_W-1:0]   cand;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic               cur_tx;
  logic               cur_eop;
  logic               xfer;
  logic               eop_xfer;
  logic               stall_q;

  // Handshake of the current owner; last_q always names the owner while ACTIVE
  assign cur_tx   = req_tx_i[last_q];
  assign cur_eop  = req_eop_i[last_q];
  assign xfer     = (state_q == ACTIVE) && cur_tx && cr_i;
  assign eop_xfer = xfer && cur_eop;

  // Round-robin search starting after the last winner; owner is masked during handoff
  always_comb begin
    arb_req   = req_tx_i;
    cand      = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    if (state_q == ACTIVE) begin
      arb_req[last_q] = 1'b0;
    end
    for (int unsigned k = 1; k <= N_PORTS; k++) begin
      cand = IDX_W'((32'(last_q) + k) % N_PORTS);
      if (!win_valid && arb_req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State, grant and priority pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state: grant from IDLE, hold across stalls, hand off on the EOP transfer
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = ACTIVE;
          grant_d = N_PORTS'(1) << win_idx;
          last_d  = win_idx;
        end
      end
      ACTIVE: begin
        if (eop_xfer) begin
          if (win_valid) begin
            grant_d = N_PORTS'(1) << win_idx;
            last_d  = win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Link mux and credit return for the owner; everything quiet when not ACTIVE
  always_comb begin
    tx_o     = 1'b0;
    eop_o    = 1'b0;
    data_o   = '0;
    req_cr_o = '0;
    if (state_q == ACTIVE) begin
      tx_o             = cur_tx;
      eop_o            = cur_eop;
      data_o           = req_data_i[32'(last_q) * FLIT_SIZE +: FLIT_SIZE];
      req_cr_o[last_q] = cr_i;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == ACTIVE);
  assign stall_o = stall_q;

  generate
    if (TIMEOUT > 0) begin : g_wdog
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_inc;

      assign cnt_inc = cnt_q + CNT_W'(1);

      // Count stalled ACTIVE cycles; pulse and restart each time TIMEOUT is reached
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          cnt_q   <= '0;
          stall_q <= 1'b0;
        end else begin
          stall_q <= 1'b0;
          if ((state_q != ACTIVE) || xfer) begin
            cnt_q <= '0;
          end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
            cnt_q   <= '0;
            stall_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
      end
    end else begin : g_no_wdog
      assign stall_q = 1'b0;
    end
  endgenerate

endmodule
